// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave: pin synchronizers, edge detection, WIDTH-bit shift in/out,
// valid/ready rx port and one-word tx buffer. Optional macro SPI_GLITCH_FILTER_EN.
module spi_slave_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]       tx_buf_q, tx_buf_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_empty_q, tx_empty_d;
  logic                   overrun_q, overrun_d;
  logic                   miso_q, miso_d;
  logic                   busy_q, busy_d;

  logic             sclk_s, cs_s, mosi_s, sclk_lvl;
  logic             sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic             do_load;
  logic [WIDTH-1:0] load_word;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

`ifdef SPI_GLITCH_FILTER_EN
  // The history flop doubles as the filtered level: it only follows sclk_s
  // once two consecutive synced samples agree.
  logic sclk_prev_q, sclk_prev_d;
  always_comb begin
    sclk_prev_d = sclk_s;
    sclk_lvl    = (sclk_s == sclk_prev_q) ? sclk_s : sclk_hist_q;
  end
  always_ff @(posedge clk) begin
    if (rst) sclk_prev_q <= 1'b0;
    else     sclk_prev_q <= sclk_prev_d;
  end
`else
  assign sclk_lvl = sclk_s;
`endif

  assign sclk_rise = sclk_lvl & ~sclk_hist_q;
  assign sclk_fall = ~sclk_lvl & sclk_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign load_word = tx_empty_q ? '0 : tx_buf_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_hist_d = sclk_lvl;
    cs_hist_d   = cs_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_buf_d    = tx_buf_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    tx_empty_d  = tx_empty_q;
    overrun_d   = overrun_q;
    miso_d      = miso_q;
    do_load     = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (tx_empty_q && tx_valid) begin
      tx_buf_d   = tx_data;
      tx_empty_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          do_load   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
        end else if (sclk_rise) begin
          if (bit_cnt_q != CNT_FULL) begin
            rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            // A completion may land in the same cycle the consumer accepts.
            if (bit_cnt_q == CNT_LAST) begin
              if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_shift_d;
                rx_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == CNT_FULL) begin
            bit_cnt_d = '0;
            do_load   = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            miso_d     = tx_shift_q[WIDTH-2];
          end
        end
      end
    endcase

    if (do_load) begin
      tx_shift_d = load_word;
      miso_d     = load_word[WIDTH-1];
      if (!tx_empty_q) tx_empty_d = 1'b1;
    end
    if (overrun_clr) overrun_d = 1'b0;
    busy_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_empty_q  <= 1'b1;
      overrun_q   <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_empty_q  <= tx_empty_d;
      overrun_q   <= overrun_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
    end
  end

  assign spi_miso = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_empty_q;
  assign overrun  = overrun_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: bit-level SPI master, queue of expected
// rx words from a bit-stream model, monitor popping on each rx handshake.
module tb_spi_slave_ctrl;
  localparam int W    = 8;
  localparam int HALF = 10;
`ifdef SPI_GLITCH_FILTER_EN
  localparam int SCLK_LAT     = 4;
  localparam bit GLITCH_SEEN  = 1'b0;
`else
  localparam int SCLK_LAT     = 3;
  localparam bit GLITCH_SEEN  = 1'b1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [W-1:0] rx_data, tx_data;
  logic         rx_valid, rx_ready, tx_valid, tx_ready;
  logic         overrun, overrun_clr, busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mosi_words[4];
  logic [W-1:0] miso_words[4];
  logic rdy_rand_mode = 1'b0;
  logic rdy_force     = 1'b1;
  logic rdy_rand      = 1'b1;

  assign rx_ready = rdy_rand_mode ? rdy_rand : rdy_force;

  spi_slave_ctrl #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      rdy_rand = ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: a handshake seen here is committed on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected: got %0h required no word", rx_data);
        end else begin
          check("rx_word", rx_data, exp_q.pop_front());
        end
      end
    end
  end

  // Reference: serialise MOSI bits (an unfiltered glitch inserts a copy of the
  // bit on the line), then every complete W-bit group is a delivered word.
  task automatic push_stream(input int nbits, input int glitch_bit);
    logic bits[$];
    logic [W-1:0] w;
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_bit && GLITCH_SEEN) bits.push_back(mosi_words[i / W][W - 1 - (i % W)]);
      bits.push_back(mosi_words[i / W][W - 1 - (i % W)]);
    end
    for (int k = 0; (k + 1) * W <= bits.size(); k++) begin
      w = '0;
      for (int j = 0; j < W; j++) w = {w[W-2:0], bits[k * W + j]};
      exp_q.push_back(w);
    end
  endtask

  task automatic spi_frame(input int nbits, input int pulse_bit, input int glitch_bit);
    for (int k = 0; k < 4; k++) miso_words[k] = '0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_words[i / W][W - 1 - (i % W)];
      if (i == glitch_bit) begin
        repeat (HALF / 2) @(negedge clk);
        spi_sclk = 1'b1;
        @(negedge clk);
        spi_sclk = 1'b0;
        repeat (HALF - HALF / 2 - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      spi_sclk = 1'b1;
      miso_words[i / W][W - 1 - (i % W)] = spi_miso;
      if (i == pulse_bit) begin
        repeat (SCLK_LAT - 1) @(negedge clk);
        rdy_force = 1'b1;
        @(negedge clk);
        rdy_force = 1'b0;
        repeat (HALF - SCLK_LAT) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      spi_sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
  endtask

  task automatic tx_write(input logic [W-1:0] v);
    int t = 0;
    @(negedge clk);
    while (!tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) begin
      n_checks++;
      $display("FAIL tx_ready_timeout: got 0 required 1");
    end
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_full", tx_ready, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0; overrun_clr = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_miso", spi_miso, 0);
    check("rst_rx_data", rx_data, 0);
    rst = 1'b0;
    repeat (HALF) @(negedge clk);

    // Single frame, empty tx buffer
    mosi_words[0] = 8'hA5;
    push_stream(8, -1);
    spi_frame(8, -1, -1);
    repeat (HALF) @(negedge clk);
    check("single_overrun", overrun, 0);
    check("single_miso", miso_words[0], 0);

    // Transmit buffered word, then zeros
    tx_write(8'h3C);
    mosi_words[0] = 8'h5A; mosi_words[1] = 8'hC3;
    push_stream(16, -1);
    spi_frame(16, -1, -1);
    repeat (HALF) @(negedge clk);
    check("tx_miso_w0", miso_words[0], 8'h3C);
    check("tx_miso_w1", miso_words[1], 8'h00);
    check("tx_ready_empty", tx_ready, 1);

    // Overrun
    rdy_force = 1'b0;
    mosi_words[0] = 8'h11; mosi_words[1] = 8'h22;
    exp_q.push_back(8'h11);
    spi_frame(16, -1, -1);
    repeat (HALF) @(negedge clk);
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_rx_data", rx_data, 8'h11);
    check("ovr_flag", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_cleared", overrun, 0);
    rdy_force = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_drained", rx_valid, 0);

    // Accept in the completion cycle of word 2
    rdy_force = 1'b0;
    mosi_words[0] = 8'h44; mosi_words[1] = 8'h99;
    push_stream(16, -1);
    spi_frame(16, 15, -1);
    repeat (HALF) @(negedge clk);
    check("simul_rx_valid", rx_valid, 1);
    check("simul_rx_data", rx_data, 8'h99);
    check("simul_overrun", overrun, 0);
    rdy_force = 1'b1;
    repeat (3) @(negedge clk);

    // Abort after 5 bits, then a full frame
    mosi_words[0] = 8'h5E;
    spi_frame(5, -1, -1);
    repeat (2) @(negedge clk);
    check("abort_busy_hold", busy, 1);
    @(negedge clk);
    check("abort_busy_fall", busy, 0);
    repeat (HALF) @(negedge clk);
    mosi_words[0] = 8'h81;
    push_stream(8, -1);
    spi_frame(8, -1, -1);
    repeat (HALF) @(negedge clk);
    check("abort_overrun", overrun, 0);

    // One-cycle SCLK glitch before bit 3
    mosi_words[0] = 8'hB6;
    push_stream(8, 3);
    spi_frame(8, -1, 3);
    repeat (HALF) @(negedge clk);

    // Randomised frames with a randomly stalling consumer
    rdy_rand_mode = 1'b1;
    for (int f = 0; f < 15; f++) begin
      int nw;
      logic wr;
      logic [W-1:0] tv;
      nw = $urandom_range(1, 3);
      wr = 1'($urandom_range(0, 1));
      tv = W'($urandom);
      if (wr) tx_write(tv);
      for (int k = 0; k < nw; k++) mosi_words[k] = W'($urandom);
      push_stream(nw * W, -1);
      spi_frame(nw * W, -1, -1);
      repeat (HALF) @(negedge clk);
      check("rand_miso_w0", miso_words[0], wr ? tv : '0);
      for (int k = 1; k < nw; k++) check("rand_miso_wn", miso_words[k], 0);
    end
    rdy_rand_mode = 1'b0;
    rdy_force     = 1'b1;
    repeat (20) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    check("final_overrun", overrun, 0);
    check("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
